// File: rtl/dm_pkg.sv
// Shared debug-module encodings: DTM operation codes and the sticky DMI error values.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    NoError  = 2'd0,
    Reserved = 2'd1,
    OpFailed = 2'd2,
    Busy     = 2'd3
  } dmi_error_e;

endpackage

// File: rtl/dmi_jtag_ctrl.sv
// DMI access controller: owns the dmi data register, turns update-DR into DMI requests
// and tracks the sticky dtmcs.dmistat error.
module dmi_jtag_ctrl
  import dm::*;
#(
  parameter int unsigned AbitsDmi      = 7,
  parameter bit          WaitWriteResp = 1'b1
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                test_logic_reset_i,
  input  logic                capture_dr_i,
  input  logic                shift_dr_i,
  input  logic                update_dr_i,
  input  logic                dmi_access_i,
  input  logic                dtmcs_select_i,
  input  logic                dmi_reset_i,
  input  logic                dmi_hardreset_i,
  input  logic                dmi_tdi_i,
  output logic                dmi_tdo_o,
  output logic [1:0]          dmi_error_o,
  output logic                busy_o,
  output logic [AbitsDmi-1:0] req_addr_o,
  output logic [31:0]         req_data_o,
  output logic [1:0]          req_op_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  input  logic [31:0]         resp_data_i,
  input  logic [1:0]          resp_status_i,
  input  logic                resp_valid_i,
  output logic                resp_ready_o,
  output logic [2:0]          dbg_state_o
);

  localparam int unsigned DrWidth = AbitsDmi + 34;

  typedef struct packed {
    logic [AbitsDmi-1:0] address;
    logic [31:0]         data;
    logic [1:0]          op;
  } dmi_dr_t;

  typedef enum logic [2:0] {
    Idle      = 3'd0,
    Read      = 3'd1,
    WaitRead  = 3'd2,
    Write     = 3'd3,
    WaitWrite = 3'd4
  } state_e;

  // Request handshake: req_valid_o rises in Read/Write and is held until the cycle
  // req_ready_i is sampled high; responses are always accepted (resp_ready_o = 1).

  state_e              state_q, state_d;
  dmi_dr_t             dr_q, dr_d;
  logic [AbitsDmi-1:0] addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  dmi_error_e          error_q, error_d;
  logic                abort_q, abort_d;
  logic                busy_cond, op_failed, hard_reset;
  logic [1:0]          capture_st;

  assign hard_reset = dmi_hardreset_i && dtmcs_select_i;
  assign busy_cond  = (update_dr_i && (state_q != Idle)) ||
                      (capture_dr_i && (state_q inside {Read, WaitRead, WaitWrite}));
  assign capture_st = (error_q != NoError) ? error_q : (busy_cond ? Busy : NoError);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    abort_d   = abort_q;
    op_failed = 1'b0;
    unique case (state_q)
      Idle: begin
        if (update_dr_i && dmi_access_i && (error_q == NoError)) begin
          addr_d = dr_q.address;
          data_d = dr_q.data;
          if (dr_q.op == DTM_READ)       state_d = Read;
          else if (dr_q.op == DTM_WRITE) state_d = Write;
        end
      end
      // A hard reset during a pending request waits for the handshake before aborting.
      Read: begin
        if (req_ready_i)     state_d = (hard_reset || abort_q) ? Idle : WaitRead;
        else if (hard_reset) abort_d = 1'b1;
      end
      Write: begin
        if (req_ready_i)     state_d = (hard_reset || abort_q || !WaitWriteResp) ? Idle : WaitWrite;
        else if (hard_reset) abort_d = 1'b1;
      end
      WaitRead: begin
        if (hard_reset) state_d = Idle;
        else if (resp_valid_i) begin
          data_d    = resp_data_i;
          op_failed = (resp_status_i != 2'd0);
          state_d   = Idle;
        end
      end
      WaitWrite: begin
        if (hard_reset) state_d = Idle;
        else if (resp_valid_i) begin
          op_failed = (resp_status_i != 2'd0);
          state_d   = Idle;
        end
      end
      default: state_d = Idle;
    endcase
    if (state_d == Idle) abort_d = 1'b0;

    error_d = error_q;
    if (error_q == NoError) begin
      if (busy_cond)      error_d = Busy;
      else if (op_failed) error_d = OpFailed;
    end
    if (dtmcs_select_i && (dmi_reset_i || dmi_hardreset_i)) error_d = NoError;
  end

  always_comb begin
    dr_d = dr_q;
    if (test_logic_reset_i) begin
      dr_d = '0;
    end else if (dmi_access_i) begin
      if (capture_dr_i) begin
        dr_d.address = addr_q;
        dr_d.data    = data_q;
        dr_d.op      = capture_st;
      end else if (shift_dr_i) begin
        dr_d = dmi_dr_t'({dmi_tdi_i, dr_q[DrWidth-1:1]});
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= Idle;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= NoError;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
      abort_q <= abort_d;
    end
  end

  assign dmi_tdo_o    = dr_q[0];
  assign dmi_error_o  = error_q;
  assign busy_o       = (state_q != Idle);
  assign req_addr_o   = addr_q;
  assign req_data_o   = data_q;
  assign req_valid_o  = (state_q == Read) || (state_q == Write);
  assign req_op_o     = (state_q == Read)  ? DTM_READ :
                        (state_q == Write) ? DTM_WRITE : DTM_NOP;
  assign resp_ready_o = 1'b1;
  assign dbg_state_o  = state_q;

endmodule
